// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS control unit (Moore FSM)
//
// Sequences the shared ALU, the unified instruction/data memory port, the
// register file and the PC of a multicycle MIPS datapath. The FSM decodes
// op/funct from the instruction register and stalls memory states on memReady.
//
// Optional feature macro: MC_CONTROL_BNE_EN (adds bne through the BEQEX state).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset, forces FETCH
//   op         - instruction[31:26]
//   funct      - instruction[5:0]
//   zero       - ALU zero flag
//   memReady   - memory completes the current access this cycle
//   memAccess  - memory request strobe
//   memWrite   - memory write enable
//   irWrite    - instruction register load enable
//   iorD       - memory address select (0 PC, 1 ALUOut)
//   regDst     - write register select (0 rt, 1 rd)
//   memToReg   - write data select (0 ALUOut, 1 Data)
//   regWrite   - register file write enable
//   aluSrcA    - ALU operand A select (0 PC, 1 A)
//   aluSrcB    - ALU operand B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   aluControl - ALU operation code
//   pcSrc      - next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   pcEn       - PC load enable
//   state      - current state, for debug

module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               memReady,
    output logic               memAccess,
    output logic               memWrite,
    output logic               irWrite,
    output logic               iorD,
    output logic               regDst,
    output logic               memToReg,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [2:0]         aluControl,
    output logic [1:0]         pcSrc,
    output logic               pcEn,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        RTYPEEX = STATE_W'(6),
        RTYPEWB = STATE_W'(7),
        BEQEX   = STATE_W'(8),
        ADDIEX  = STATE_W'(9),
        ADDIWB  = STATE_W'(10),
        JEX     = STATE_W'(11)
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUBT = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    state_t state_q;
    state_t state_d;
    logic [2:0] rtype_alu;

    assign state = state_q;

    // Outputs decode straight from state_q, so an asynchronous reset drops any
    // write enable in the same cycle without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        rtype_alu = ALU_ADD;
        case (funct)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUBT;
            FN_AND:  rtype_alu = ALU_AND;
            FN_OR:   rtype_alu = ALU_OR;
            FN_SLT:  rtype_alu = ALU_SLT;
            default: rtype_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d    = FETCH;
        memAccess  = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        iorD       = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluControl = 3'b000;
        pcSrc      = 2'b00;
        pcEn       = 1'b0;

        case (state_q)
            FETCH: begin
                // PC+4 and the IR load both commit only when the fetch completes.
                memAccess  = 1'b1;
                aluSrcB    = 2'b01;
                aluControl = ALU_ADD;
                irWrite    = memReady;
                pcEn       = memReady;
                state_d    = memReady ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                aluSrcB    = 2'b11;
                aluControl = ALU_ADD;
                case (op)
                    OP_LW,
                    OP_SW:    state_d = MEMADR;
                    OP_RTYPE: state_d = RTYPEEX;
                    OP_BEQ:   state_d = BEQEX;
`ifdef MC_CONTROL_BNE_EN
                    OP_BNE:   state_d = BEQEX;
`endif
                    OP_ADDI:  state_d = ADDIEX;
                    OP_J:     state_d = JEX;
                    default:  state_d = FETCH;
                endcase
            end
            MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                if (op == OP_LW) begin
                    state_d = MEMRD;
                end else if (op == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD: begin
                memAccess = 1'b1;
                iorD      = 1'b1;
                state_d   = memReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                regDst   = 1'b0;
                state_d  = FETCH;
            end
            MEMWR: begin
                // memWrite is held through stalls; memory commits on memReady.
                memAccess = 1'b1;
                memWrite  = 1'b1;
                iorD      = 1'b1;
                state_d   = memReady ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b00;
                aluControl = rtype_alu;
                state_d    = RTYPEWB;
            end
            RTYPEWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                memToReg = 1'b0;
                state_d  = FETCH;
            end
            BEQEX: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b00;
                aluControl = ALU_SUBT;
                pcSrc      = 2'b01;
`ifdef MC_CONTROL_BNE_EN
                // bne shares this state with the branch sense inverted.
                pcEn       = zero ^ (op == OP_BNE);
`else
                pcEn       = zero;
`endif
                state_d    = FETCH;
            end
            ADDIEX: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                state_d    = ADDIWB;
            end
            ADDIWB: begin
                regWrite = 1'b1;
                regDst   = 1'b0;
                memToReg = 1'b0;
                state_d  = FETCH;
            end
            JEX: begin
                pcSrc   = 2'b10;
                pcEn    = 1'b1;
                state_d = FETCH;
            end
            default: begin
                // Unused encodings: all outputs low, recover to FETCH.
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm

module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic       memAccess;
    logic       memWrite;
    logic       irWrite;
    logic       iorD;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memReady   (memReady),
        .memAccess  (memAccess),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .iorD       (iorD),
        .regDst     (regDst),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluControl (aluControl),
        .pcSrc      (pcSrc),
        .pcEn       (pcEn),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short asynchronous pulse between edges, leaves the FSM in FETCH.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        memReady = 1'b1;
        op       = 6'b000000;
        funct    = 6'b100000;
        zero     = 1'b0;
        step();
        step();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++;
        if (irWrite !== 1'b1 || pcEn !== 1'b1) begin
            errors++; $display("FAIL reset_ir_pc: irWrite=%b pcEn=%b want 1 1", irWrite, pcEn);
        end
        checks++;
        if (aluSrcB !== 2'b01 || aluControl !== 3'b010 || memAccess !== 1'b1) begin
            errors++; $display("FAIL reset_alu: aluSrcB=%b aluControl=%b memAccess=%b want 01 010 1",
                               aluSrcB, aluControl, memAccess);
        end
        checks++;
        if (regWrite !== 1'b0 || memWrite !== 1'b0 || pcSrc !== 2'b00 || aluSrcA !== 1'b0) begin
            errors++; $display("FAIL reset_others: regWrite=%b memWrite=%b pcSrc=%b aluSrcA=%b want 0",
                               regWrite, memWrite, pcSrc, aluSrcA);
        end
        reset = 1'b0;
        step();
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL reset_release: got %0d want 1", state); end
        memReady = 1'b0;
        do_reset();
    endtask

    task automatic test_lw();
        int exp_st[6];
        int exp_io[6];
        exp_st = '{0, 1, 2, 3, 4, 0};
        exp_io = '{0, 0, 0, 1, 0, 0};
        do_reset();
        op       = 6'b100011;
        memReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (state !== 4'(exp_st[i])) begin
                errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            end
            checks++;
            if (regWrite !== (exp_st[i] == 4) || memToReg !== (exp_st[i] == 4)) begin
                errors++; $display("FAIL lw_wb[%0d]: regWrite=%b memToReg=%b want %0d",
                                   i, regWrite, memToReg, exp_st[i] == 4);
            end
            checks++;
            if (iorD !== 1'(exp_io[i])) begin
                errors++; $display("FAIL lw_iord[%0d]: got %b want %0d", i, iorD, exp_io[i]);
            end
            step();
        end
    endtask

    task automatic test_sw_stall();
        int exp_st[8];
        int mr[8];
        exp_st = '{0, 1, 2, 5, 5, 5, 5, 0};
        mr     = '{1, 1, 1, 0, 0, 0, 1, 1};
        do_reset();
        op = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            memReady = 1'(mr[i]);
            #1;
            checks++;
            if (state !== 4'(exp_st[i])) begin
                errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            end
            checks++;
            if (memWrite !== (exp_st[i] == 5) || regWrite !== 1'b0) begin
                errors++; $display("FAIL sw_ctrl[%0d]: memWrite=%b regWrite=%b want %0d 0",
                                   i, memWrite, regWrite, exp_st[i] == 5);
            end
            step();
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn[6];
        logic [2:0] ac[6];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        ac = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        memReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            op    = 6'b000000;
            funct = fn[i];
            step();
            step();
            checks++;
            if (state !== 4'd6 || aluControl !== ac[i] || aluSrcA !== 1'b1 || aluSrcB !== 2'b00) begin
                errors++; $display("FAIL rtype_ex[%0d]: state=%0d aluControl=%b srcA=%b srcB=%b want 6 %b 1 00",
                                   i, state, aluControl, aluSrcA, aluSrcB, ac[i]);
            end
            step();
            checks++;
            if (state !== 4'd7 || regDst !== 1'b1 || regWrite !== 1'b1 || memToReg !== 1'b0) begin
                errors++; $display("FAIL rtype_wb[%0d]: state=%0d regDst=%b regWrite=%b memToReg=%b want 7 1 1 0",
                                   i, state, regDst, regWrite, memToReg);
            end
            step();
            checks++;
            if (state !== 4'd0) begin errors++; $display("FAIL rtype_done[%0d]: got %0d want 0", i, state); end
        end
        funct = 6'b100000;
    endtask

    task automatic test_branch();
        memReady = 1'b1;
        do_reset();
        op   = 6'b000100;
        zero = 1'b1;
        step();
        step();
        checks++;
        if (state !== 4'd8 || pcEn !== 1'b1 || pcSrc !== 2'b01 || aluControl !== 3'b110) begin
            errors++; $display("FAIL beq_taken: state=%0d pcEn=%b pcSrc=%b aluControl=%b want 8 1 01 110",
                               state, pcEn, pcSrc, aluControl);
        end
        zero = 1'b0;
        #1;
        checks++;
        if (pcEn !== 1'b0) begin errors++; $display("FAIL beq_not_taken: pcEn=%b want 0", pcEn); end
        step();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL beq_done: got %0d want 0", state); end

        do_reset();
        op   = 6'b000101;
        zero = 1'b1;
        step();
`ifdef MC_CONTROL_BNE_EN
        step();
        checks++;
        if (state !== 4'd8 || pcEn !== 1'b0) begin
            errors++; $display("FAIL bne_zero1: state=%0d pcEn=%b want 8 0", state, pcEn);
        end
        zero = 1'b0;
        #1;
        checks++;
        if (pcEn !== 1'b1) begin errors++; $display("FAIL bne_zero0: pcEn=%b want 1", pcEn); end
`else
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL bne_decode: got %0d want 1", state); end
        step();
        checks++;
        if (state !== 4'd0 || pcEn !== 1'b1) begin
            errors++; $display("FAIL bne_nop: state=%0d pcEn=%b want 0 1", state, pcEn);
        end
`endif
        zero = 1'b0;
    endtask

    task automatic test_jump();
        memReady = 1'b1;
        do_reset();
        op = 6'b000010;
        step();
        step();
        checks++;
        if (state !== 4'd11 || pcEn !== 1'b1 || pcSrc !== 2'b10 || memAccess !== 1'b0) begin
            errors++; $display("FAIL jump_ex: state=%0d pcEn=%b pcSrc=%b memAccess=%b want 11 1 10 0",
                               state, pcEn, pcSrc, memAccess);
        end
    endtask

    task automatic test_latency();
        logic [5:0] ops[7];
        int         lat[7];
        int         cnt;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b111111};
        lat = '{5, 4, 4, 4, 3, 3, 2};
        memReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_reset();
            op  = ops[i];
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (state !== 4'd0 && cnt < 20);
            checks++;
            if (cnt != lat[i]) begin
                errors++; $display("FAIL latency[op=%b]: got %0d cycles want %0d", ops[i], cnt, lat[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        memReady = 1'b1;
        do_reset();
        op = 6'b100011;
        step();
        step();
        step();
        checks++;
        if (state !== 4'd3) begin errors++; $display("FAIL abort_setup: got %0d want 3", state); end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || regWrite !== 1'b0) begin
            errors++; $display("FAIL abort_async: state=%0d regWrite=%b want 0 0", state, regWrite);
        end
        memReady = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (state !== 4'd0 || regWrite !== 1'b0) begin
                errors++; $display("FAIL abort_after[%0d]: state=%0d regWrite=%b want 0 0", i, state, regWrite);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_branch();
        test_jump();
        test_latency();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
